// File: rtl/acumulador_monedas.sv
// acumulador_monedas: coin credit accumulator, purchase charge and change payout.
// Define ACUM_DEBOUNCE_EN to add a per-bit debounce filter on the coin inputs.
module acumulador_monedas #(
  parameter int unsigned VAL0        = 1,
  parameter int unsigned VAL1        = 2,
  parameter int unsigned VAL2        = 5,
  parameter int unsigned VAL3        = 10,
  parameter int unsigned MAX_CREDITO = 15,
  parameter int unsigned PULSE_GAP   = 4
`ifdef ACUM_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Monedas,
  input  logic [3:0] precio,
  input  logic       compra_aceptada,
  input  logic       cancelar,
  output logic [3:0] Acumulador_Monedas,
  output logic       moneda_rechazada,
  output logic       vuelto_pulso,
  output logic       ocupado
);

  typedef enum logic [1:0] {
    IDLE,
    CREDITO,
    COBRO,
    VUELTO
  } state_t;

  localparam int GW = $clog2(PULSE_GAP);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(PULSE_GAP - 1);

  logic [3:0] sync1_q, sync2_q, prev_q, lvl, rise;
  logic ca_q, ca_prev_q, cn_q, cn_prev_q;
  logic ca_rise, cn_rise;

  state_t state_q, state_d;
  logic [3:0] credito_q, credito_d, cred_coin;
  logic [GW-1:0] gap_q, gap_d;
  logic rech_q, rech_d, pulso_q, pulso_d, ocup_q;

  logic [4:0] coin_val, suma;
  logic coin_any, coin_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      ca_q      <= 1'b0;
      ca_prev_q <= 1'b0;
      cn_q      <= 1'b0;
      cn_prev_q <= 1'b0;
    end else begin
      sync1_q   <= Monedas;
      sync2_q   <= sync1_q;
      prev_q    <= lvl;
      ca_q      <= compra_aceptada;
      ca_prev_q <= ca_q;
      cn_q      <= cancelar;
      cn_prev_q <= cn_q;
    end
  end

`ifdef ACUM_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [3:0]    filt_q;
  logic [DW-1:0] cnt_q [4];

  // Filtered level flips only after a run of consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign rise    = lvl & ~prev_q;
  assign ca_rise = ca_q & ~ca_prev_q;
  assign cn_rise = cn_q & ~cn_prev_q;

  always_comb begin
    coin_val = '0;
    case (rise)
      4'b0001: coin_val = 5'(VAL0);
      4'b0010: coin_val = 5'(VAL1);
      4'b0100: coin_val = 5'(VAL2);
      4'b1000: coin_val = 5'(VAL3);
      default: coin_val = '0;
    endcase
    coin_any = |rise;
    suma     = {1'b0, credito_q} + coin_val;
    coin_ok  = $onehot(rise) && (suma <= 5'(MAX_CREDITO));
  end

  always_comb begin
    state_d   = state_q;
    credito_d = credito_q;
    gap_d     = gap_q;
    rech_d    = coin_any;
    pulso_d   = 1'b0;
    cred_coin = coin_ok ? suma[3:0] : credito_q;
    unique case (state_q)
      IDLE, CREDITO: begin
        // Coin is applied first; cancel/purchase see the updated credit.
        rech_d    = coin_any && !coin_ok;
        credito_d = cred_coin;
        state_d   = (cred_coin != 4'd0) ? CREDITO : IDLE;
        if (cn_rise) begin
          if (cred_coin != 4'd0) begin
            state_d   = VUELTO;
            credito_d = cred_coin - 4'd1;
            pulso_d   = 1'b1;
            gap_d     = GAP_RELOAD;
          end
        end else if (ca_rise && (cred_coin >= precio)) begin
          state_d   = COBRO;
          credito_d = cred_coin - precio;
        end
      end
      COBRO: begin
        if (credito_q != 4'd0) begin
          state_d   = VUELTO;
          credito_d = credito_q - 4'd1;
          pulso_d   = 1'b1;
          gap_d     = GAP_RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      VUELTO: begin
        if (credito_q == 4'd0) begin
          state_d = IDLE;
        end else if (gap_q == '0) begin
          credito_d = credito_q - 4'd1;
          pulso_d   = 1'b1;
          gap_d     = GAP_RELOAD;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      credito_q <= '0;
      gap_q     <= '0;
      rech_q    <= 1'b0;
      pulso_q   <= 1'b0;
      ocup_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credito_q <= credito_d;
      gap_q     <= gap_d;
      rech_q    <= rech_d;
      pulso_q   <= pulso_d;
      ocup_q    <= (state_d == COBRO) || (state_d == VUELTO);
    end
  end

  assign Acumulador_Monedas = credito_q;
  assign moneda_rechazada   = rech_q;
  assign vuelto_pulso       = pulso_q;
  assign ocupado            = ocup_q;

endmodule

// File: tb/tb_acumulador_monedas.sv
// tb_acumulador_monedas: directed table, corner sequences and random
// transactions checked against a credit-level reference model.
module tb_acumulador_monedas;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Monedas;
  logic [3:0] precio;
  logic       compra;
  logic       cancelar;
  logic [3:0] Acumulador_Monedas;
  logic       moneda_rechazada;
  logic       vuelto_pulso;
  logic       ocupado;

  always #5 clk = ~clk;

  acumulador_monedas dut (
    .clk               (clk),
    .rst               (rst),
    .Monedas           (Monedas),
    .precio            (precio),
    .compra_aceptada   (compra),
    .cancelar          (cancelar),
    .Acumulador_Monedas(Acumulador_Monedas),
    .moneda_rechazada  (moneda_rechazada),
    .vuelto_pulso      (vuelto_pulso),
    .ocupado           (ocupado)
  );

`ifdef ACUM_DEBOUNCE_EN
  localparam int LAT  = 19;
  localparam int HOLD = 24;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 6;
`endif
  localparam int GAP  = 4;
  localparam int MAXC = 15;

  localparam int OP_COIN = 0;
  localparam int OP_BUY  = 1;
  localparam int OP_CAN  = 2;
  localparam int OP_BOTH = 3;

  typedef struct {
    int         op;
    logic [3:0] arg;
    int         cred;
    int         rej;
    int         pul;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int rej_cnt = 0;
  int pul_cnt = 0;
  bit ocup_seen = 1'b0;
  int pul_t[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (moneda_rechazada) rej_cnt++;
    if (vuelto_pulso) begin
      pul_cnt++;
      pul_t.push_back(cyc);
    end
    if (ocupado) ocup_seen = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    Monedas  = '0;
    precio   = '0;
    compra   = 1'b0;
    cancelar = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic coin(input logic [3:0] m);
    Monedas = m;
    tick(HOLD);
    Monedas = '0;
    tick(HOLD);
  endtask

  task automatic wait_idle();
    tick(4);
    for (int i = 0; i < 300 && ocupado; i++) tick(1);
    chk("idle_timeout", int'(ocupado), 0);
    tick(2);
  endtask

  task automatic req(input logic [3:0] p, input bit canc, input bit comp);
    precio   = p;
    compra   = comp;
    cancelar = canc;
    tick(3);
    compra   = 1'b0;
    cancelar = 1'b0;
    wait_idle();
  endtask

  task automatic apply(input int op, input logic [3:0] arg);
    case (op)
      OP_COIN: coin(arg);
      OP_BUY:  req(arg, 1'b0, 1'b1);
      OP_CAN:  req(arg, 1'b1, 1'b0);
      default: req(arg, 1'b1, 1'b1);
    endcase
  endtask

  initial begin
    vec_t vt[$];
    int vals[4];
    int r0, p0, mc, sel, er, ep, bi, bj;
    logic [3:0] m, p;
    vals = '{1, 2, 5, 10};

    do_reset();
    chk("rst_credit", int'(Acumulador_Monedas), 0);
    chk("rst_rech", int'(moneda_rechazada), 0);
    chk("rst_pulse", int'(vuelto_pulso), 0);
    chk("rst_ocup", int'(ocupado), 0);

    // Coin latency: credit appears on the LAT-th edge after the drive.
    Monedas = 4'b0100;
    tick(LAT - 1);
    chk("lat5_before", int'(Acumulador_Monedas), 0);
    tick(1);
    chk("lat5_after", int'(Acumulador_Monedas), 5);
    Monedas = '0;
    tick(HOLD);
    Monedas = 4'b0001;
    tick(LAT - 1);
    chk("lat6_before", int'(Acumulador_Monedas), 5);
    tick(1);
    chk("lat6_after", int'(Acumulador_Monedas), 6);
    Monedas = '0;
    tick(HOLD);
    chk("lat_no_rej", rej_cnt, 0);

    // Purchase change pulses and their spacing.
    do_reset();
    coin(4'b0100);
    coin(4'b0010);
    coin(4'b0001);
    chk("spc_credit8", int'(Acumulador_Monedas), 8);
    pul_t.delete();
    ocup_seen = 1'b0;
    req(4'd5, 1'b0, 1'b1);
    chk("spc_npulses", pul_t.size(), 3);
    if (pul_t.size() == 3) begin
      chk("spc_gap1", pul_t[1] - pul_t[0], GAP);
      chk("spc_gap2", pul_t[2] - pul_t[1], GAP);
    end
    chk("spc_ocup", int'(ocup_seen), 1);
    chk("spc_credit0", int'(Acumulador_Monedas), 0);

    // Coin inserted while paying change is rejected.
    do_reset();
    coin(4'b1000);
    r0 = rej_cnt;
    p0 = pul_cnt;
    cancelar = 1'b1;
    tick(3);
    cancelar = 1'b0;
    chk("vu_ocup", int'(ocupado), 1);
    coin(4'b0001);
    wait_idle();
    chk("vu_rej", rej_cnt - r0, 1);
    chk("vu_pulses", pul_cnt - p0, 10);
    chk("vu_credit", int'(Acumulador_Monedas), 0);

    // Unaffordable purchase ignored, then reset during change payout.
    do_reset();
    coin(4'b0010);
    coin(4'b0010);
    req(4'd6, 1'b0, 1'b1);
    chk("poor_credit", int'(Acumulador_Monedas), 4);
    p0 = pul_cnt;
    cancelar = 1'b1;
    for (int i = 0; i < 50 && pul_cnt == p0; i++) tick(1);
    chk("rstv_pulse_seen", int'(pul_cnt > p0), 1);
    rst = 1'b1;
    tick(1);
    chk("rstv_credit", int'(Acumulador_Monedas), 0);
    chk("rstv_ocup", int'(ocupado), 0);
    chk("rstv_pulse", int'(vuelto_pulso), 0);
    chk("rstv_rech", int'(moneda_rechazada), 0);
    cancelar = 1'b0;
    rst = 1'b0;
    p0 = pul_cnt;
    tick(30);
    chk("rstv_no_more", pul_cnt - p0, 0);

`ifdef ACUM_DEBOUNCE_EN
    do_reset();
    Monedas = 4'b0001;
    tick(5);
    Monedas = '0;
    tick(40);
    chk("db_glitch", int'(Acumulador_Monedas), 0);
    Monedas = 4'b0001;
    tick(20);
    Monedas = '0;
    tick(40);
    chk("db_pulse", int'(Acumulador_Monedas), 1);
`endif

    vt.push_back('{OP_COIN, 4'b1000, 10, 0, 0});
    vt.push_back('{OP_COIN, 4'b0100, 15, 0, 0});
    vt.push_back('{OP_COIN, 4'b0001, 15, 1, 0});
    vt.push_back('{OP_COIN, 4'b0011, 15, 1, 0});
    vt.push_back('{OP_CAN,  4'd0,     0, 0, 15});
    vt.push_back('{OP_COIN, 4'b0100,  5, 0, 0});
    vt.push_back('{OP_COIN, 4'b0010,  7, 0, 0});
    vt.push_back('{OP_COIN, 4'b0001,  8, 0, 0});
    vt.push_back('{OP_BUY,  4'd5,     0, 0, 3});
    vt.push_back('{OP_COIN, 4'b0100,  5, 0, 0});
    vt.push_back('{OP_COIN, 4'b0010,  7, 0, 0});
    vt.push_back('{OP_BOTH, 4'd3,     0, 0, 7});
    vt.push_back('{OP_COIN, 4'b0010,  2, 0, 0});
    vt.push_back('{OP_COIN, 4'b0010,  4, 0, 0});
    vt.push_back('{OP_BUY,  4'd6,     4, 0, 0});
    vt.push_back('{OP_BUY,  4'd4,     0, 0, 0});
    vt.push_back('{OP_COIN, 4'b0001,  1, 0, 0});
    vt.push_back('{OP_BUY,  4'd0,     0, 0, 1});

    do_reset();
    foreach (vt[k]) begin
      r0 = rej_cnt;
      p0 = pul_cnt;
      apply(vt[k].op, vt[k].arg);
      chk($sformatf("vec%0d_credit", k), int'(Acumulador_Monedas), vt[k].cred);
      chk($sformatf("vec%0d_rej", k), rej_cnt - r0, vt[k].rej);
      chk($sformatf("vec%0d_pulses", k), pul_cnt - p0, vt[k].pul);
    end

    // Random transactions against a credit-level model.
    do_reset();
    mc = 0;
    for (int k = 0; k < 150; k++) begin
      r0  = rej_cnt;
      p0  = pul_cnt;
      er  = 0;
      ep  = 0;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) begin
        bi = int'($urandom_range(0, 3));
        m  = 4'(1 << bi);
        if (mc + vals[bi] <= MAXC) mc = mc + vals[bi];
        else er = 1;
        coin(m);
      end else if (sel == 6) begin
        bi = int'($urandom_range(0, 3));
        bj = (bi + 1 + int'($urandom_range(0, 2))) % 4;
        m  = 4'((1 << bi) | (1 << bj));
        er = 1;
        coin(m);
      end else if (sel <= 8) begin
        p = 4'($urandom_range(0, 15));
        if (mc >= int'(p)) begin
          ep = mc - int'(p);
          mc = 0;
        end
        req(p, 1'b0, 1'b1);
      end else begin
        ep = mc;
        mc = 0;
        req(4'd0, 1'b1, 1'b0);
      end
      chk($sformatf("rnd%0d_credit", k), int'(Acumulador_Monedas), mc);
      chk($sformatf("rnd%0d_rej", k), rej_cnt - r0, er);
      chk($sformatf("rnd%0d_pulses", k), pul_cnt - p0, ep);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/acumulador_monedas.md
Name: acumulador_monedas

Overview:
Coin-credit stage directly upstream of the coffee selector. Synchronises the four coin-sensor inputs, detects insertion edges, accumulates credit into the 4-bit Acumulador_Monedas bus that the selector compares against the drink price, charges on purchase acceptance, and pays back remaining credit as change pulses. Also handles overflow rejection and cancel.

Parameters:
VAL0, 1, credit value of Monedas[0]
VAL1, 2, credit value of Monedas[1]
VAL2, 5, credit value of Monedas[2]
VAL3, 10, credit value of Monedas[3]
MAX_CREDITO, 15, maximum credit; must fit in 4 bits
PULSE_GAP, 4, clk cycles between successive change pulses (>=2)
DEBOUNCE_CYCLES, 16, stable cycles required when ACUM_DEBOUNCE_EN is defined

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
Monedas  in  4  asynchronous coin-sensor levels, one bit per denomination
precio  in  4  price of the current selection, from selector
compra_aceptada  in  1  selector's accept level (LEDS_Aceptada)
cancelar  in  1  user cancel, level
Acumulador_Monedas  out  4  current credit
moneda_rechazada  out  1  one-cycle pulse: coin rejected
vuelto_pulso  out  1  one-cycle pulse per credit unit returned
ocupado  out  1  high in COBRO/VUELTO; coins rejected

Behaviour:
- Reset: state IDLE, credit 0, moneda_rechazada 0, vuelto_pulso 0, ocupado 0, synchroniser and edge registers 0, gap counter 0.
- Input path: Monedas through 2-FF synchroniser, then a previous-value register; rise = sync & ~prev per bit. Latency: credit updates on the 3rd rising clk edge after the pin is first sampled high.
- compra_aceptada and cancelar are used as rising edges of their registered value, with no synchroniser (selector is synchronous; cancelar is a debounced button).
- States: IDLE (credit 0), CREDITO (credit > 0), COBRO (one cycle), VUELTO.
- Coin rise in IDLE/CREDITO:
  - exactly one bit rising: new = credit + VALn, computed 5 bits wide. If new <= MAX_CREDITO, credit = new and go to CREDITO. Otherwise credit is unchanged and moneda_rechazada pulses.
  - two or more bits rising in the same cycle: reject all, pulse moneda_rechazada once, no credit.
- Coin rise in COBRO/VUELTO: rejected; moneda_rechazada pulses.
- CREDITO, compra_aceptada rise with credit >= precio: go to COBRO; credit = credit - precio on entry.
- CREDITO, compra_aceptada rise with credit < precio: ignored.
- COBRO: next state is VUELTO if credit > 0, else IDLE.
- CREDITO, cancelar rise: go to VUELTO with full credit.
- Cancel priority: cancelar and compra_aceptada rising together means cancel wins.
- Coin priority: a coin and compra_aceptada/cancelar in the same cycle are evaluated as coin first, then the purchase check uses the updated credit. A cancel in the same cycle returns the updated credit.
- VUELTO:
  - vuelto_pulso asserts for 1 cycle on entry, then every PULSE_GAP cycles.
  - credit decrements by 1 in the same cycle as each pulse.
  - When credit reaches 0 after a pulse, go to IDLE; no further pulse is issued.
  - Pulses issued always equal the credit on entry.
- ocupado = (state == COBRO || state == VUELTO), registered with state.
- rst mid-VUELTO: credit is cleared and no further pulses are issued (lost change is accepted behaviour).
- IDLE/CREDITO with precio = 0 and accept: COBRO charges 0, then VUELTO returns the full credit.

Optional Feature:
ACUM_DEBOUNCE_EN:
- Defined: each synchronised bit passes through a per-bit counter. The filtered level changes only after the input differs from it for DEBOUNCE_CYCLES consecutive cycles; edge detection uses the filtered level. Latency grows by DEBOUNCE_CYCLES.
- Undefined: no filter; glitches of >= 1 cycle count as coins.

Test Plan:
- Reset, insert Monedas[2] (5) then Monedas[0] (1) -> Acumulador_Monedas 5 then 6, each 3 cycles after its pin rise; moneda_rechazada stays 0.
- Credit 10, insert Monedas[2] (+5 -> 15) then Monedas[0] -> credit 15, second coin rejected: one moneda_rechazada pulse, credit stays 15.
- Monedas = 4'b0011 rising in the same cycle -> one rejection pulse, credit unchanged.
- Credit 8, precio 5, compra_aceptada rise -> credit 3 after COBRO; ocupado high; 3 vuelto_pulso spaced 4 cycles; credit 0; IDLE.
- Credit 7, cancelar and compra_aceptada rising together -> 7 change pulses; no charge.
- Credit 4, precio 6, compra_aceptada rise -> ignored, credit 4; then rst during VUELTO after cancel -> all outputs 0 next cycle.
- With ACUM_DEBOUNCE_EN defined, a 5-cycle glitch on Monedas[0] -> no credit; a 20-cycle pulse -> +1.
